// File: rtl/intersection_scheduler.sv
// Two-road intersection controller with a single shared down-counter for phase timing.
// Optional pedestrian crossing phase enabled by defining PED_CROSS_EN.
module intersection_scheduler #(
    parameter int G_MIN     = 8,
    parameter int G_MAX     = 20,
    parameter int Y_TIME    = 3,
    parameter int AR_TIME   = 2,
    parameter int WALK_TIME = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_btn,
    output logic       main_g,
    output logic       main_y,
    output logic       main_r,
    output logic       side_g,
    output logic       side_y,
    output logic       side_r,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_AR2 = 3'd5,
        S_WK  = 3'd6
    } state_t;

    // Once SG has run G_MIN cycles the counter sits at or below this value.
    localparam logic [7:0] L_SG_MIN_CNT = 8'(G_MAX - G_MIN);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_count;
    logic       r_side_req;
    logic       w_ped_pend;
    logic       w_enter_wk;
    logic       w_expired;
    logic [6:0] r_lamps;

    function automatic logic [7:0] load_val(input state_t s);
        case (s)
            S_MG:    load_val = 8'(G_MIN - 1);
            S_MY:    load_val = 8'(Y_TIME - 1);
            S_AR1:   load_val = 8'(AR_TIME - 1);
            S_SG:    load_val = 8'(G_MAX - 1);
            S_SY:    load_val = 8'(Y_TIME - 1);
            S_AR2:   load_val = 8'(AR_TIME - 1);
            S_WK:    load_val = 8'(WALK_TIME - 1);
            default: load_val = 8'(G_MIN - 1);
        endcase
    endfunction

    // Lamp vector order: main_g, main_y, main_r, side_g, side_y, side_r, walk.
    function automatic logic [6:0] lamp_decode(input state_t s);
        case (s)
            S_MG:    lamp_decode = 7'b100_001_0;
            S_MY:    lamp_decode = 7'b010_001_0;
            S_AR1:   lamp_decode = 7'b001_001_0;
            S_SG:    lamp_decode = 7'b001_100_0;
            S_SY:    lamp_decode = 7'b001_010_0;
            S_AR2:   lamp_decode = 7'b001_001_0;
            S_WK:    lamp_decode = 7'b001_001_1;
            default: lamp_decode = 7'b001_001_0;
        endcase
    endfunction

    assign w_expired  = (r_count == 8'd0);
    assign w_enter_wk = (w_next_state == S_WK) && (r_state != S_WK);

`ifdef PED_CROSS_EN
    logic r_ped_pend;

    // Pending pedestrian request; a press always wins over the WK-entry clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped_pend <= 1'b0;
        end else if (ped_btn) begin
            r_ped_pend <= 1'b1;
        end else if (w_enter_wk) begin
            r_ped_pend <= 1'b0;
        end else begin
            r_ped_pend <= r_ped_pend;
        end
    end

    assign w_ped_pend = r_ped_pend;
`else
    logic w_unused_ped;

    assign w_unused_ped = ped_btn | w_enter_wk;
    assign w_ped_pend   = 1'b0;
`endif

    // Side-road sensor is registered so phase decisions see a clean, edge-aligned demand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_side_req <= 1'b0;
        end else begin
            r_side_req <= side_req;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_MG: begin
                if (w_expired && (r_side_req || w_ped_pend)) begin
                    w_next_state = S_MY;
                end else begin
                    w_next_state = S_MG;
                end
            end
            S_MY: begin
                if (w_expired) begin
                    w_next_state = S_AR1;
                end else begin
                    w_next_state = S_MY;
                end
            end
            S_AR1: begin
                if (!w_expired) begin
                    w_next_state = S_AR1;
                end else if (w_ped_pend) begin
                    w_next_state = S_WK;
                end else if (r_side_req) begin
                    w_next_state = S_SG;
                end else begin
                    w_next_state = S_AR2;
                end
            end
            S_SG: begin
                if (w_expired || ((r_count <= L_SG_MIN_CNT) && !r_side_req)) begin
                    w_next_state = S_SY;
                end else begin
                    w_next_state = S_SG;
                end
            end
            S_SY: begin
                if (w_expired) begin
                    w_next_state = S_AR2;
                end else begin
                    w_next_state = S_SY;
                end
            end
            S_AR2: begin
                if (w_expired) begin
                    w_next_state = S_MG;
                end else begin
                    w_next_state = S_AR2;
                end
            end
            S_WK: begin
                if (!w_expired) begin
                    w_next_state = S_WK;
                end else if (r_side_req) begin
                    w_next_state = S_SG;
                end else begin
                    w_next_state = S_AR2;
                end
            end
            default: w_next_state = S_MG;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_MG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase timer: reload on every state change, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'(G_MIN - 1);
        end else if (w_next_state != r_state) begin
            r_count <= load_val(w_next_state);
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Lamps registered from the next state so they always track r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lamps <= lamp_decode(S_MG);
        end else begin
            r_lamps <= lamp_decode(w_next_state);
        end
    end

    assign {main_g, main_y, main_r, side_g, side_y, side_r, walk} = r_lamps;
    assign phase = r_state;

endmodule
